nibble_tx: RTL and testbench

//   Transmit side of the 4-bit load-strobe link (data nibble + "control" load enable).

---
 rtl/nibble_link_pkg.sv | 14 +
 rtl/nibble_tx.sv | 145 ++++++++++++++
 tb/tb_nibble_tx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_link_pkg.sv
// Shared definitions for the 4-bit load-strobe link: FSM encoding and default widths.
package nibble_link_pkg;

  localparam int unsigned NIB_W_DEFAULT = 4;
  localparam int unsigned GAP_CNT_W     = 4;
  localparam int unsigned GAP_MAX       = (1 << GAP_CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage : nibble_link_pkg

// File: rtl/nibble_tx.sv
// Transmit side of the nibble load-strobe link: accepts a word over valid/ready and
// serializes it into NIB_W-bit beats, each qualified by a one-cycle control strobe.
module nibble_tx
  import nibble_link_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NIB_W     = NIB_W_DEFAULT,
  parameter int unsigned GAP       = 0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [NIB_W-1:0]  out,
  output logic              control,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BEATS = WORD_W / NIB_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((WORD_W % NIB_W) != 0 || BEATS == 0) begin : g_bad_width
    $error("nibble_tx: WORD_W must be a non-zero multiple of NIB_W");
  end
  if (GAP > GAP_MAX) begin : g_bad_gap
    $error("nibble_tx: GAP out of range");
  end

  state_t                r_state,      w_state_nxt;
  logic [WORD_W-1:0]     r_shift,      w_shift_nxt;
  logic [NIB_W-1:0]      r_out,        w_out_nxt;
  logic                  r_control,    w_control_nxt;
  logic                  r_busy,       w_busy_nxt;
  logic                  r_done,       w_done_nxt;
  logic                  r_word_ready, w_word_ready_nxt;
  logic [CNT_W-1:0]      r_beat_cnt,   w_beat_cnt_nxt;
  logic [GAP_CNT_W-1:0]  r_gap_cnt,    w_gap_cnt_nxt;

  // Head beat of the incoming word / of the remaining shift contents, and what remains after it.
  logic [NIB_W-1:0]  w_head_in, w_head_sh;
  logic [WORD_W-1:0] w_rest_in, w_rest_sh;

  if (MSB_FIRST) begin : g_msb
    assign w_head_in = word_in[WORD_W-1 -: NIB_W];
    assign w_head_sh = r_shift[WORD_W-1 -: NIB_W];
    assign w_rest_in = word_in << NIB_W;
    assign w_rest_sh = r_shift << NIB_W;
  end else begin : g_lsb
    assign w_head_in = word_in[NIB_W-1:0];
    assign w_head_sh = r_shift[NIB_W-1:0];
    assign w_rest_in = word_in >> NIB_W;
    assign w_rest_sh = r_shift >> NIB_W;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_out        <= '0;
      r_control    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_ready <= 1'b1;
      r_beat_cnt   <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_out        <= w_out_nxt;
      r_control    <= w_control_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_word_ready <= w_word_ready_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
    end
  end

  // Next-state and next-output logic; control and done are single-cycle by default.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_out_nxt      = r_out;
    w_control_nxt  = 1'b0;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_beat_cnt_nxt = r_beat_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (word_valid && r_word_ready) begin
          w_shift_nxt    = w_rest_in;
          w_out_nxt      = w_head_in;
          w_control_nxt  = 1'b1;
          w_busy_nxt     = 1'b1;
          w_beat_cnt_nxt = CNT_W'(BEATS - 1);
          w_state_nxt    = ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (r_beat_cnt == '0) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (GAP == 0) begin
          w_shift_nxt    = w_rest_sh;
          w_out_nxt      = w_head_sh;
          w_control_nxt  = 1'b1;
          w_beat_cnt_nxt = r_beat_cnt - CNT_W'(1);
        end else begin
          w_gap_cnt_nxt = GAP_CNT_W'(GAP - 1);
          w_state_nxt   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) begin
          w_shift_nxt    = w_rest_sh;
          w_out_nxt      = w_head_sh;
          w_control_nxt  = 1'b1;
          w_beat_cnt_nxt = r_beat_cnt - CNT_W'(1);
          w_state_nxt    = ST_BEAT;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_word_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  assign word_ready = r_word_ready;
  assign out        = r_out;
  assign control    = r_control;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule : nibble_tx

// File: tb/tb_nibble_tx.sv
// Bench for nibble_tx: three instances (MSB/GAP0, LSB/GAP0, MSB/GAP2) on shared stimulus,
// each with a timeline model, a load-enabled 4-bit receiver register and literal checks.
module tb_nibble_tx;

  localparam int BEATS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic [2:0]  ready, ctrl, busy, done;
  logic [3:0]  outv [3];
  logic [3:0]  rx [3];
  logic [31:0] logv [3];

  int errors = 0;
  int checks = 0;
  int d1 [3];
  int d2 [3];

  always #5 clk = ~clk;

  nibble_tx #(.WORD_W(32), .NIB_W(4), .GAP(0), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready[0]), .out(outv[0]), .control(ctrl[0]), .busy(busy[0]), .done(done[0]));
  nibble_tx #(.WORD_W(32), .NIB_W(4), .GAP(0), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready[1]), .out(outv[1]), .control(ctrl[1]), .busy(busy[1]), .done(done[1]));
  nibble_tx #(.WORD_W(32), .NIB_W(4), .GAP(2), .MSB_FIRST(1'b1)) u_gap (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready[2]), .out(outv[2]), .control(ctrl[2]), .busy(busy[2]), .done(done[2]));

  // Far-end load-enabled 4-bit registers.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) rx[i] <= '0;
      else if (ctrl[i]) rx[i] <= outv[i];
    end
  end

  function automatic int gap_of(input int i);
    return (i == 2) ? 2 : 0;
  endfunction

  function automatic bit msb_of(input int i);
    return (i != 1);
  endfunction

  // Cycle index (1 = cycle after accept) of the last strobe.
  function automatic int last_t(input int i);
    return (BEATS - 1) * (1 + gap_of(i)) + 1;
  endfunction

  function automatic bit in_busy(input int t, input int i);
    return (t >= 1) && (t <= last_t(i));
  endfunction

  function automatic logic [3:0] nib(input logic [31:0] w, input bit msb, input int k);
    logic [31:0] s;
    int pos;
    pos = msb ? (BEATS - 1 - k) : k;
    s = w >> (pos * 4);
    return s[3:0];
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h want %0h", name, i, act, exp);
    end
  endtask

  // Model: per instance, t counts cycles since the accepting edge; everything follows from t.
  int          m_t [3];
  logic [31:0] m_word [3];
  logic [3:0]  m_out [3];

  always @(posedge clk or negedge rst_n) begin : p_model
    int nt;
    logic [31:0] nw;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_t[i]    <= 0;
        m_word[i] <= '0;
        m_out[i]  <= '0;
      end else begin
        if (!in_busy(m_t[i], i) && word_valid) begin
          nw = word_in;
          nt = 1;
        end else begin
          nw = m_word[i];
          nt = in_busy(m_t[i], i) ? m_t[i] + 1 : 0;
        end
        m_word[i] <= nw;
        m_t[i]    <= nt;
        if (in_busy(nt, i)) m_out[i] <= nib(nw, msb_of(i), (nt - 1) / (1 + gap_of(i)));
      end
    end
  end

  // Every-cycle comparison against the model, plus a log of strobed beats.
  always @(negedge clk) begin : p_cmp
    int t;
    bit b_e;
    for (int i = 0; i < 3; i++) begin
      t   = m_t[i];
      b_e = in_busy(t, i);
      check("ready",   i, 32'(ready[i]), 32'(!b_e));
      check("busy",    i, 32'(busy[i]),  32'(b_e));
      check("done",    i, 32'(done[i]),  32'(t == last_t(i) + 1));
      check("control", i, 32'(ctrl[i]),  32'(b_e && (((t - 1) % (1 + gap_of(i))) == 0)));
      check("out",     i, 32'(outv[i]),  32'(m_out[i]));
      if (ctrl[i]) logv[i] = {logv[i][27:0], outv[i]};
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (ready !== 3'b111 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_wait", 0, 32'(ready), 32'h7);
  endtask

  // Send w; optionally drive inj_w with valid high for inj_len cycles starting inj_k cycles after accept.
  task automatic run(input logic [31:0] w, input int inj_k, input logic [31:0] inj_w, input int inj_len);
    wait_idle();
    @(posedge clk); #1;
    word_in    = w;
    word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d1[i] = 0;
      d2[i] = 0;
    end
    for (int k = 1; k <= 60; k++) begin
      if (inj_len > 0 && k == inj_k) begin
        word_in    = inj_w;
        word_valid = 1'b1;
      end
      if (inj_len > 0 && k == inj_k + inj_len) word_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          if (d1[i] == 0) d1[i] = k;
          else if (d2[i] == 0) d2[i] = k;
        end
      end
      @(posedge clk); #1;
    end
    word_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", i, 32'(ready[i]), 32'h1);
      check("rst_ctrl",  i, 32'(ctrl[i]),  32'h0);
      check("rst_busy",  i, 32'(busy[i]),  32'h0);
      check("rst_out",   i, 32'(outv[i]),  32'h0);
    end
    rst_n = 1'b1;

    // MSB/LSB ordering, gap spacing, receiver final contents.
    run(32'h1234ABCD, 0, 32'h0, 0);
    check("t1_log",  0, logv[0], 32'h1234ABCD);
    check("t1_done", 0, 32'(d1[0]), 32'd9);
    check("t2_log",  1, logv[1], 32'hDCBA4321);
    check("t2_rx",   1, 32'(rx[1]), 32'h1);
    check("t1_rx",   0, 32'(rx[0]), 32'hD);
    check("gap_log", 2, logv[2], 32'h1234ABCD);
    check("gap_done", 2, 32'(d1[2]), 32'd23);

    run(32'hF0F0F0F0, 0, 32'h0, 0);
    check("t3_log",  2, logv[2], 32'hF0F0F0F0);
    check("t3_done", 2, 32'(d1[2]), 32'd23);
    check("t3_lsb",  1, logv[1], 32'h0F0F0F0F);

    // Back-to-back: valid held, second word accepted in the done cycle.
    run(32'h11111111, 1, 32'h22222222, 9);
    check("t4_done1", 0, 32'(d1[0]), 32'd9);
    check("t4_done2", 0, 32'(d2[0]), 32'd18);
    check("t4_log",   0, logv[0], 32'h22222222);
    check("t4_lsb",   1, logv[1], 32'h22222222);
    check("t4_gap",   2, logv[2], 32'h11111111);
    check("t4_gapd2", 2, 32'(d2[2]), 32'd0);

    // Mid-transfer valid pulse is ignored.
    run(32'h1234ABCD, 3, 32'hDEADBEEF, 1);
    check("t5_log",  0, logv[0], 32'h1234ABCD);
    check("t5_lsb",  1, logv[1], 32'hDCBA4321);
    check("t5_gap",  2, logv[2], 32'h1234ABCD);
    check("t5_done", 0, 32'(d1[0]), 32'd9);

    // Reset after the third beat, then a clean word.
    wait_idle();
    @(posedge clk); #1;
    word_in    = 32'h1234ABCD;
    word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_pre_out", 0, 32'(outv[0]), 32'h3);
    #1 rst_n = 1'b0;
    #1;
    check("t6_ctrl",  0, 32'(ctrl[0]),  32'h0);
    check("t6_busy",  0, 32'(busy[0]),  32'h0);
    check("t6_out",   0, 32'(outv[0]),  32'h0);
    check("t6_done",  0, 32'(done[0]),  32'h0);
    check("t6_ready", 0, 32'(ready[0]), 32'h1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(32'h1234ABCD, 0, 32'h0, 0);
    check("t6_log",  0, logv[0], 32'h1234ABCD);
    check("t6_done2", 0, 32'(d1[0]), 32'd9);
    check("t6_rx",   0, 32'(rx[0]), 32'hD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nibble_tx
